// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer for the 4-stage core: RAW scoreboard over stages 3/4,
// stall/flush/drain/halt sequencing and the fetch/decode enable and bubble controls.
module pipeline_sequencer #(
  parameter int unsigned WIDTH               = 32,
  parameter int unsigned INSTRACTION_NUMBERS = 16,
  parameter int unsigned REG_ADDR_W          = 5,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      pc_out,
  input  logic [REG_ADDR_W-1:0] src1_addr,
  input  logic                  src1_used,
  input  logic [REG_ADDR_W-1:0] src2_addr,
  input  logic                  src2_used,
  input  logic [REG_ADDR_W-1:0] dst_addr,
  input  logic                  dst_we,
  input  logic                  is_branch_fault,
  output logic                  is_load_PC,
  output logic                  is_load_for_launch_1_2,
  output logic                  nop_step_2,
  output logic                  nop_step_3,
  output logic                  nop_step_4,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalt} state_e;

  localparam logic [WIDTH-1:0] PcEnd = WIDTH'(INSTRACTION_NUMBERS);

  state_e                state_q, state_d;
  logic                  sb3_valid_q, sb3_valid_d, sb4_valid_q, sb4_valid_d;
  logic [REG_ADDR_W-1:0] sb3_addr_q, sb3_addr_d, sb4_addr_q, sb4_addr_d;
  logic                  retire_q, retire_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  src1_hit, src2_hit, hazard, pc_end, stall, flush;

  assign pc_end = (pc_out >= PcEnd);

  assign src1_hit = src1_used && (src1_addr != '0) &&
                    ((sb3_valid_q && (sb3_addr_q == src1_addr)) ||
                     (sb4_valid_q && (sb4_addr_q == src1_addr)));
  assign src2_hit = src2_used && (src2_addr != '0) &&
                    ((sb3_valid_q && (sb3_addr_q == src2_addr)) ||
                     (sb4_valid_q && (sb4_addr_q == src2_addr)));
  assign hazard   = src1_hit || src2_hit;

  always_comb begin
    state_d                = state_q;
    retire_d               = 1'b0;
    stall                  = 1'b0;
    flush                  = 1'b0;
    is_load_PC             = 1'b0;
    is_load_for_launch_1_2 = 1'b0;
    nop_step_2             = 1'b1;
    nop_step_3             = 1'b1;
    nop_step_4             = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun, StDrain: begin
        if (is_branch_fault) begin
          flush                  = 1'b1;
          is_load_PC             = 1'b1;
          is_load_for_launch_1_2 = 1'b1;
          state_d                = StRun;
        end else begin
          if (hazard) begin
            stall      = 1'b1;
            nop_step_2 = (state_q == StDrain);
            nop_step_4 = 1'b0;
          end else begin
            is_load_PC             = (state_q == StRun) && !pc_end;
            is_load_for_launch_1_2 = 1'b1;
            nop_step_2             = (state_q == StDrain);
            nop_step_3             = 1'b0;
            nop_step_4             = 1'b0;
          end
          if (state_q == StRun) begin
            if (pc_end) state_d = StDrain;
          end else if (!sb3_valid_q && !sb4_valid_q) begin
            // Scoreboard empty: wait one extra cycle so stage 4 retires before halting.
            if (retire_q) state_d = StHalt;
            else          retire_d = 1'b1;
          end
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sb4_valid_d = sb3_valid_q;
    sb4_addr_d  = sb3_addr_q;
    sb3_valid_d = dst_we && (dst_addr != '0) && !nop_step_2;
    sb3_addr_d  = dst_addr;
    if (flush) begin
      sb3_valid_d = 1'b0;
      sb4_valid_d = 1'b0;
    end else if (stall) begin
      sb3_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sb3_valid_q <= 1'b0;
      sb3_addr_q  <= '0;
      sb4_valid_q <= 1'b0;
      sb4_addr_q  <= '0;
      retire_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sb3_valid_q <= sb3_valid_d;
      sb3_addr_q  <= sb3_addr_d;
      sb4_valid_q <= sb4_valid_d;
      sb4_addr_q  <= sb4_addr_d;
      retire_q    <= retire_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
